// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared state encoding and constants for the instruction-memory loader
package loader_pkg;

    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_CKSUM = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam state_t RST_STATE     = ST_IDLE;
    localparam logic   RST_FLAG      = 1'b0;
    localparam logic   RST_CORE_RSTN = 1'b0;

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream, control/status and memory-write bundle of the loader
interface imem_loader_if #(
    parameter int ADDR_W = 8,
    parameter int WORD_W = 32
);
    logic              Start;
    logic [ADDR_W:0]   Len;
    logic [7:0]        ByteIn;
    logic              ByteValid;
    logic              ByteReady;
    logic              MemWrt;
    logic [ADDR_W-1:0] MemAddr;
    logic [WORD_W-1:0] MemData;
    logic              CoreRstN;
    logic              Busy;
    logic              Done;
    logic              Err;

    modport master (
        output Start, Len, ByteIn, ByteValid,
        input  ByteReady, MemWrt, MemAddr, MemData, CoreRstN, Busy, Done, Err
    );

    modport slave (
        input  Start, Len, ByteIn, ByteValid,
        output ByteReady, MemWrt, MemAddr, MemData, CoreRstN, Busy, Done, Err
    );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// rtl/imem_loader_byte_packer.sv - assembles accepted bytes into big-endian words
module byte_packer
    import loader_pkg::*;
#(
    parameter int WORD_W = BYTE_W * BYTES_PER_WORD
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              accept,
    input  logic [BYTE_W-1:0] data,
    output logic [WORD_W-1:0] word,
    output logic              word_full
);
    localparam int                CNT_W     = $clog2(BYTES_PER_WORD);
    localparam logic [CNT_W-1:0]  LAST_SLOT = CNT_W'(BYTES_PER_WORD - 1);

    logic [CNT_W-1:0]  cnt_q;
    logic [WORD_W-1:0] shift_q;

    // The counter wraps back to slot 0 on the last byte, so a new word starts clean.
    assign word_full = accept && (cnt_q == LAST_SLOT);
    assign word      = shift_q;

    // Shift each byte in at the low end so the first byte of a word ends up most significant.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else if (accept) begin
            cnt_q   <= cnt_q + 1'b1;
            shift_q <= {shift_q[WORD_W-BYTE_W-1:0], data};
        end
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - loads a byte-stream program into instruction memory, holds core in reset; LOADER_CKSUM_EN adds a trailing XOR checksum byte
module imem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int WORD_W = 32
) (
    input  logic         Clk,
    input  logic         Rst,
    imem_loader_if.slave bus
);
    localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};

`ifdef LOADER_CKSUM_EN
    localparam state_t AFTER_LAST = ST_CKSUM;
`else
    localparam state_t AFTER_LAST = ST_DONE;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              byte_ready_q, byte_ready_d;
    logic              mem_wrt_q, mem_wrt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              core_rstn_q, core_rstn_d;
`ifdef LOADER_CKSUM_EN
    logic              err_q, err_d;
    logic [BYTE_W-1:0] csum_q, csum_d;
`endif

    logic              accept;
    logic              pack_accept;
    logic              word_full;
    logic              last_word;
    logic [WORD_W-1:0] word;

    assign accept      = bus.ByteValid && byte_ready_q;
    assign pack_accept = accept && (state_q == ST_RECV);
    assign last_word   = ({1'b0, idx_q} == (len_q - 1'b1));

    byte_packer #(
        .WORD_W (WORD_W)
    ) u_packer (
        .clk       (Clk),
        .resetn    (Rst),
        .accept    (pack_accept),
        .data      (bus.ByteIn),
        .word      (word),
        .word_full (word_full)
    );

    // State register.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q <= RST_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, load bookkeeping, and the next values of the registered outputs
    // (decoded from the next state so every output lines up with the state it belongs to).
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
`ifdef LOADER_CKSUM_EN
        err_d   = err_q;
        csum_d  = csum_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.Start) begin
                    len_d   = (bus.Len > LEN_MAX) ? LEN_MAX : bus.Len;
                    idx_d   = '0;
`ifdef LOADER_CKSUM_EN
                    err_d   = 1'b0;
                    csum_d  = '0;
`endif
                    state_d = (bus.Len == '0) ? AFTER_LAST : ST_RECV;
                end
            end
            ST_RECV: begin
`ifdef LOADER_CKSUM_EN
                if (accept) begin
                    csum_d = csum_q ^ bus.ByteIn;
                end
`endif
                if (word_full) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (last_word) begin
                    state_d = AFTER_LAST;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_RECV;
                end
            end
`ifdef LOADER_CKSUM_EN
            ST_CKSUM: begin
                if (accept) begin
                    err_d   = (bus.ByteIn != csum_q);
                    state_d = ST_DONE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        byte_ready_d = (state_d == ST_RECV) || (state_d == ST_CKSUM);
        mem_wrt_d    = (state_d == ST_WRITE);
        busy_d       = (state_d == ST_RECV) || (state_d == ST_WRITE) || (state_d == ST_CKSUM);
        done_d       = (state_d == ST_DONE);
`ifdef LOADER_CKSUM_EN
        // A load with a bad checksum must not let the core run.
        core_rstn_d  = (state_d == ST_IDLE) || ((state_d == ST_DONE) && !err_d);
`else
        core_rstn_d  = (state_d == ST_IDLE) || (state_d == ST_DONE);
`endif
    end

    // Output and bookkeeping registers.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            len_q        <= '0;
            idx_q        <= '0;
            byte_ready_q <= RST_FLAG;
            mem_wrt_q    <= RST_FLAG;
            busy_q       <= RST_FLAG;
            done_q       <= RST_FLAG;
            core_rstn_q  <= RST_CORE_RSTN;
`ifdef LOADER_CKSUM_EN
            err_q        <= RST_FLAG;
            csum_q       <= '0;
`endif
        end else begin
            len_q        <= len_d;
            idx_q        <= idx_d;
            byte_ready_q <= byte_ready_d;
            mem_wrt_q    <= mem_wrt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            core_rstn_q  <= core_rstn_d;
`ifdef LOADER_CKSUM_EN
            err_q        <= err_d;
            csum_q       <= csum_d;
`endif
        end
    end

    // The word index doubles as the write address; the packer register holds the
    // complete word for the whole WRITE cycle.
    assign bus.ByteReady = byte_ready_q;
    assign bus.MemWrt    = mem_wrt_q;
    assign bus.MemAddr   = idx_q;
    assign bus.MemData   = word;
    assign bus.CoreRstN  = core_rstn_q;
    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;
`ifdef LOADER_CKSUM_EN
    assign bus.Err       = err_q;
`else
    assign bus.Err       = 1'b0;
`endif

endmodule
